// File: rtl/seg_display_scanner_if.sv
// Bus between processor-side status signals and the seven-segment scanner.
// Master drives processor values and reads the display; slave is the scanner.
interface seg_display_scanner_if;
  logic [7:0] out_val;
  logic [7:0] a_val;
  logic [3:0] state;
  logic       halt;
  logic       page;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output out_val, a_val, state, halt, page,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  out_val, a_val, state, halt, page,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed 4-digit common-anode display scanner with per-frame input snapshot.
// Optional halt blink of the value digits is enabled by defining DISP_HALT_BLINK_EN.
module seg_display_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_scanner_if.slave bus
);
  localparam int               PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC    = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [6:0]       SEG_H     = 7'b0001001;

  typedef struct packed {
    logic [7:0] out_val;
    logic [7:0] a_val;
    logic [3:0] state;
    logic       halt;
    logic       page;
  } snap_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    r = SEG_BLANK;
    case (n)
      4'h0: r = 7'b1000000;
      4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;
      4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;
      4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;
      4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0010000;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;
      4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;
      4'hF: r = 7'b0001110;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q;
  snap_t            snap_q, snap_d, snap_in;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q;
  logic             tc;
  logic             load;
  logic             blank_val;
  logic [7:0]       val;

  assign snap_in = '{out_val: bus.out_val, a_val: bus.a_val, state: bus.state,
                     halt: bus.halt, page: bus.page};

  // valid_q is low only until the first edge after reset, which forces a load.
  assign tc     = (pre_q == PRE_TC);
  assign load   = !valid_q || (tc && idx_q == 2'd3);
  assign pre_d  = tc ? '0 : pre_q + PRE_W'(1);
  assign idx_d  = tc ? idx_q + 2'd1 : idx_q;
  assign snap_d = load ? snap_in : snap_q;
  assign val    = snap_q.page ? snap_q.a_val : snap_q.out_val;

`ifdef DISP_HALT_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  // Counting restarts whenever a halt snapshot follows a non-halt one.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (load) begin
      if (!snap_in.halt || !snap_q.halt) begin
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
      end else if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign blank_val = blink_ph_q;
`else
  assign blank_val = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    if (valid_q) begin
      case (idx_q)
        2'd0:    seg_d = blank_val ? SEG_BLANK : hex7(val[3:0]);
        2'd1:    seg_d = blank_val ? SEG_BLANK : hex7(val[7:4]);
        2'd2:    seg_d = snap_q.halt ? SEG_H : SEG_BLANK;
        default: seg_d = hex7(snap_q.state);
      endcase
    end
  end

  // The last prescaler cycle of each slot stays dark to avoid ghosting.
  assign an_d = (!valid_q || tc) ? 4'b1111 : ~(4'b0001 << idx_q);
  assign dp_d = !(valid_q && idx_q == 2'd0 && snap_q.page);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      valid_q <= 1'b1;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= load;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Frame-level checks of seg_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_display_scanner;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int NV           = 14;
`ifdef DISP_HALT_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] SH = 7'b0001001, SX = 7'b1111111;

  typedef struct {
    logic [7:0] out_val;
    logic [7:0] a_val;
    logic [3:0] state;
    logic       halt;
    logic       page;
    int         chg;
    logic [6:0] s0, s1, s2, s3;
    logic       dp0;
    logic       bl;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs [NV];
  vec_t vr;
  logic [3:0][6:0] s;
  logic d0;

  seg_display_scanner_if bus_if ();

  seg_display_scanner #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.out_val = v.out_val;
    bus_if.a_val   = v.a_val;
    bus_if.state   = v.state;
    bus_if.halt    = v.halt;
    bus_if.page    = v.page;
  endtask

  // Samples the 16 cycles of one frame; the anode/tick pattern is checked per
  // cycle and each digit's segments are captured for the caller.
  task automatic run_frame(input int chg_j, input vec_t nxt, input bit first,
                           output logic [3:0][6:0] so, output logic dpo);
    int         errs;
    int         d;
    logic [3:0] seen;
    logic [3:0] an_exp;
    logic       ft_exp;
    errs = 0;
    seen = '0;
    so   = '1;
    dpo  = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      d = (j - 1) / 4;
      if ((first && j == 1) || (j % 4 == 0)) an_exp = 4'b1111;
      else an_exp = ~(4'b0001 << d);
      ft_exp = (j == 16) || (first && j == 1);
      if (bus_if.an !== an_exp) errs++;
      if (bus_if.frame_tick !== ft_exp) errs++;
      if (an_exp != 4'b1111) begin
        if (seen[d] && bus_if.seg !== so[d]) errs++;
        so[d]   = bus_if.seg;
        seen[d] = 1'b1;
        if (d == 0) dpo = bus_if.dp;
        else if (bus_if.dp !== 1'b1) errs++;
      end
      if (j == chg_j) drive(nxt);
    end
    chk("scan", errs, 0);
  endtask

  task automatic check_frame(input string tag, input logic [3:0][6:0] so, input logic dpo,
                             input vec_t v);
    logic [6:0] e0, e1;
    e0 = (BLINK_ON && v.bl) ? SX : v.s0;
    e1 = (BLINK_ON && v.bl) ? SX : v.s1;
    $display("%s: seg3=%b seg2=%b seg1=%b seg0=%b dp0=%b", tag, so[3], so[2], so[1], so[0], dpo);
    chk({tag, "_dig0"}, so[0], e0);
    chk({tag, "_dig1"}, so[1], e1);
    chk({tag, "_dig2"}, so[2], v.s2);
    chk({tag, "_dig3"}, so[3], v.s3);
    chk({tag, "_dp0"},  dpo,   v.dp0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},   bus_if.an,         4'b1111);
    chk({tag, "_seg"},  bus_if.seg,        SX);
    chk({tag, "_dp"},   bus_if.dp,         1'b1);
    chk({tag, "_tick"}, bus_if.frame_tick, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            out    a      st    h     p     chg  s0  s1  s2  s3  dp0   bl
    vecs[0]  = '{8'h5A, 8'h00, 4'h3, 1'b0, 1'b0, 0,  SA, S5, SX, S3, 1'b1, 1'b0};
    vecs[1]  = '{8'hF0, 8'h00, 4'h3, 1'b0, 1'b0, 6,  S0, SF, SX, S3, 1'b1, 1'b0};
    vecs[2]  = '{8'hF0, 8'h0C, 4'h3, 1'b0, 1'b1, 6,  SC, S0, SX, S3, 1'b0, 1'b0};
    vecs[3]  = '{8'h00, 8'hA7, 4'h9, 1'b0, 1'b1, 15, S7, SA, SX, S9, 1'b0, 1'b0};
    vecs[4]  = '{8'h12, 8'h34, 4'hE, 1'b0, 1'b0, 6,  S2, S1, SX, SE, 1'b1, 1'b0};
    vecs[5]  = '{8'h6D, 8'h00, 4'hB, 1'b1, 1'b0, 6,  SD, S6, SH, SB, 1'b1, 1'b0};
    vecs[6]  = '{8'h6D, 8'h00, 4'hB, 1'b1, 1'b0, 6,  SD, S6, SH, SB, 1'b1, 1'b0};
    vecs[7]  = '{8'h6D, 8'h00, 4'hB, 1'b1, 1'b0, 6,  SD, S6, SH, SB, 1'b1, 1'b1};
    vecs[8]  = '{8'h6D, 8'h00, 4'hB, 1'b1, 1'b0, 6,  SD, S6, SH, SB, 1'b1, 1'b1};
    vecs[9]  = '{8'h6D, 8'h00, 4'hB, 1'b1, 1'b0, 6,  SD, S6, SH, SB, 1'b1, 1'b0};
    vecs[10] = '{8'h8F, 8'h00, 4'h4, 1'b0, 1'b0, 15, SF, S8, SX, S4, 1'b1, 1'b0};
    vecs[11] = '{8'h8F, 8'h00, 4'h4, 1'b1, 1'b0, 6,  SF, S8, SH, S4, 1'b1, 1'b0};
    vecs[12] = '{8'h8F, 8'h00, 4'h4, 1'b1, 1'b0, 6,  SF, S8, SH, S4, 1'b1, 1'b0};
    vecs[13] = '{8'h8F, 8'h00, 4'h4, 1'b1, 1'b0, 6,  SF, S8, SH, S4, 1'b1, 1'b1};
    vr       = '{8'h3C, 8'h5E, 4'h1, 1'b1, 1'b1, 0,  SE, S5, SH, S1, 1'b0, 1'b0};

    reset = 1'b1;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_frame(0, vecs[0], 1'b1, s, d0);
    check_frame("frame0", s, d0, vecs[0]);

    // Each frame gets the next vector mid-frame while still showing the previous one.
    for (int i = 1; i < NV; i++) begin
      run_frame(vecs[i].chg, vecs[i], 1'b0, s, d0);
      check_frame($sformatf("frame%0d", i), s, d0, vecs[i-1]);
    end
    run_frame(0, vecs[NV-1], 1'b0, s, d0);
    check_frame($sformatf("frame%0d", NV), s, d0, vecs[NV-1]);

    // Reset pulse while digit 2 is being scanned.
    repeat (9) @(negedge clk);
    drive(vr);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    run_frame(0, vr, 1'b1, s, d0);
    check_frame("post_reset", s, d0, vr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
